// File: rtl/tage_pred_update_unit.sv
// TAGE prediction/update engine: captures one lookup, selects provider and alternate,
// then issues one cycle of table-update strobes once the branch resolves.
module tage_pred_update_unit #(
  parameter int NUM_BANKS = 4,
  parameter int CL        = 3,
  parameter int UL        = 2,
  parameter int CNT_W     = 17,
  parameter int UR_PERIOD = 256,
  parameter int PW        = $clog2(NUM_BANKS + 1)
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    lookup_valid,
  input  logic [CL-1:0]           bimodal_ctr,
  input  logic [NUM_BANKS-1:0]    bank_hit,
  input  logic [NUM_BANKS*CL-1:0] bank_ctr,
  input  logic [NUM_BANKS*UL-1:0] bank_u,
  output logic                    busy,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [PW-1:0]           provider,
  input  logic                    resolve_valid,
  input  logic                    actual_taken,
  output logic [NUM_BANKS:0]      ctr_inc,
  output logic [NUM_BANKS:0]      ctr_dec,
  output logic [NUM_BANKS-1:0]    u_inc,
  output logic [NUM_BANKS-1:0]    u_dec,
  output logic [NUM_BANKS-1:0]    alloc_we,
  output logic                    u_age_clear,
  output logic [CNT_W-1:0]        correct_cnt,
  output logic [CNT_W-1:0]        total_cnt
);

  localparam int                AGE_W    = $clog2(UR_PERIOD);
  localparam logic [AGE_W-1:0]  AGE_LAST = AGE_W'(UR_PERIOD - 1);
  localparam logic [CL-1:0]     WEAK_HI  = CL'(1 << (CL - 1));
  localparam logic [CL-1:0]     WEAK_LO  = CL'((1 << (CL - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRED, S_WAIT, S_UPD} state_t;

  state_t state_q, state_d;

  logic [CL-1:0]           lk_bim;
  logic [NUM_BANKS-1:0]    lk_hit;
  logic [NUM_BANKS*CL-1:0] lk_ctr;
  logic [NUM_BANKS*UL-1:0] lk_u;
  logic                    act_q;
  logic [AGE_W-1:0]        age_cnt;

  logic [CL-1:0] ctr_a [NUM_BANKS+1];
  logic [UL-1:0] u_a   [NUM_BANKS+1];
  int            prov_i;
  int            alt_i;
  logic [CL-1:0] prov_ctr;
  logic [CL-1:0] alt_ctr;
  logic [UL-1:0] prov_u;
  logic          prov_weak;
  logic          use_alt;
  logic          prov_msb;
  logic          alt_msb;
  logic          mispred;
  logic          alloc_found;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (lookup_valid)  state_d = S_PRED;
      S_PRED:                    state_d = S_WAIT;
      S_WAIT: if (resolve_valid) state_d = S_UPD;
      S_UPD:                     state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // NOTE: the captured lookup is reset too, because pred_taken and provider decode
  // straight from it and must read 0 out of reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lk_bim      <= '0;
      lk_hit      <= '0;
      lk_ctr      <= '0;
      lk_u        <= '0;
      act_q       <= 1'b0;
      correct_cnt <= '0;
      total_cnt   <= '0;
      age_cnt     <= '0;
    end else begin
      if (state_q == S_IDLE && lookup_valid) begin
        lk_bim <= bimodal_ctr;
        lk_hit <= bank_hit;
        lk_ctr <= bank_ctr;
        lk_u   <= bank_u;
      end
      // Statistics advance on entry to UPD so they are already visible during it.
      if (state_q == S_WAIT && resolve_valid) begin
        act_q <= actual_taken;
        if (total_cnt != '1) total_cnt <= total_cnt + 1'b1;
        if (pred_taken == actual_taken && correct_cnt != '1)
          correct_cnt <= correct_cnt + 1'b1;
      end
      if (state_q == S_UPD)
        age_cnt <= (age_cnt == AGE_LAST) ? '0 : age_cnt + 1'b1;
    end
  end

  // Index 0 is the bimodal entry; it has no useful bits.
  always_comb begin
    ctr_a[0] = lk_bim;
    u_a[0]   = '0;
    for (int k = 1; k <= NUM_BANKS; k++) begin
      ctr_a[k] = lk_ctr[(k-1)*CL +: CL];
      u_a[k]   = lk_u[(k-1)*UL +: UL];
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    prov_i = 0;
    for (int k = 1; k <= NUM_BANKS; k++)
      if (lk_hit[k-1]) prov_i = k;
    alt_i = 0;
    for (int k = 1; k <= NUM_BANKS; k++)
      if (lk_hit[k-1] && k < prov_i) alt_i = k;
    prov_ctr = '0;
    alt_ctr  = '0;
    prov_u   = '0;
    for (int k = 0; k <= NUM_BANKS; k++) begin
      if (k == prov_i) begin
        prov_ctr = ctr_a[k];
        prov_u   = u_a[k];
      end
      if (k == alt_i) alt_ctr = ctr_a[k];
    end
  end

  assign prov_weak  = (prov_ctr == WEAK_HI) || (prov_ctr == WEAK_LO);
  assign use_alt    = (prov_i != 0) && prov_weak && (prov_u == '0);
  assign prov_msb   = prov_ctr[CL-1];
  assign alt_msb    = alt_ctr[CL-1];
  assign pred_taken = use_alt ? alt_msb : prov_msb;
  assign provider   = PW'(prov_i);
  assign busy       = (state_q != S_IDLE);
  assign pred_valid = (state_q == S_PRED);
  assign mispred    = (pred_taken != act_q);

  always_comb begin
    ctr_inc     = '0;
    ctr_dec     = '0;
    u_inc       = '0;
    u_dec       = '0;
    alloc_we    = '0;
    u_age_clear = 1'b0;
    alloc_found = 1'b0;
    if (state_q == S_UPD) begin
      for (int k = 0; k <= NUM_BANKS; k++) begin
        if (k == prov_i) begin
          ctr_inc[k] = act_q  && (prov_ctr != '1);
          ctr_dec[k] = !act_q && (prov_ctr != '0);
        end
      end
      // Usefulness only moves when the provider and alternate actually disagreed.
      if (prov_i != 0 && prov_msb != alt_msb) begin
        for (int k = 1; k <= NUM_BANKS; k++) begin
          if (k == prov_i) begin
            if (prov_msb == act_q) u_inc[k-1] = (prov_u != '1);
            else                   u_dec[k-1] = (prov_u != '0);
          end
        end
      end
      if (mispred && prov_i < NUM_BANKS) begin
        for (int k = 1; k <= NUM_BANKS; k++) begin
          if (k > prov_i && !alloc_found && u_a[k] == '0) begin
            alloc_we[k-1] = 1'b1;
            alloc_found   = 1'b1;
          end
        end
        // No free victim: decay every longer-history bank so one frees up later.
        if (!alloc_found) begin
          for (int k = 1; k <= NUM_BANKS; k++)
            if (k > prov_i && u_a[k] != '0) u_dec[k-1] = 1'b1;
        end
      end
      u_age_clear = (age_cnt == AGE_LAST);
    end
  end

endmodule

// File: tb/tb_tage_pred_update_unit.sv
// Directed bench for tage_pred_update_unit: fixed lookup/resolve scenarios with
// hand-computed prediction, strobe and statistics values.
module tb_tage_pred_update_unit;

  logic        CLK;
  logic        reset;
  logic        lookup_valid;
  logic [2:0]  bimodal_ctr;
  logic [3:0]  bank_hit;
  logic [11:0] bank_ctr;
  logic [7:0]  bank_u;
  logic        busy;
  logic        pred_valid;
  logic        pred_taken;
  logic [2:0]  provider;
  logic        resolve_valid;
  logic        actual_taken;
  logic [4:0]  ctr_inc, ctr_dec;
  logic [3:0]  u_inc, u_dec, alloc_we;
  logic        u_age_clear;
  logic [16:0] correct_cnt, total_cnt;

  int tests = 0;
  int fails = 0;

  // Observations captured by run_op
  logic       o_pv, o_pt, o_wait_pv, o_wait_busy, o_wait_str, o_upd_busy, o_idle_busy, o_age;
  logic [2:0] o_prov;
  logic [4:0] o_ci, o_cd;
  logic [3:0] o_ui, o_ud, o_aw;
  logic [16:0] o_tot, o_cor;

  tage_pred_update_unit #(
    .NUM_BANKS(4), .CL(3), .UL(2), .CNT_W(17), .UR_PERIOD(4)
  ) dut (
    .CLK(CLK), .reset(reset), .lookup_valid(lookup_valid),
    .bimodal_ctr(bimodal_ctr), .bank_hit(bank_hit), .bank_ctr(bank_ctr), .bank_u(bank_u),
    .busy(busy), .pred_valid(pred_valid), .pred_taken(pred_taken), .provider(provider),
    .resolve_valid(resolve_valid), .actual_taken(actual_taken),
    .ctr_inc(ctr_inc), .ctr_dec(ctr_dec), .u_inc(u_inc), .u_dec(u_dec),
    .alloc_we(alloc_we), .u_age_clear(u_age_clear),
    .correct_cnt(correct_cnt), .total_cnt(total_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives one full lookup/resolve operation and captures outputs per phase.
  task automatic run_op(input logic [2:0] bim, input logic [3:0] hit,
                        input logic [11:0] ctr, input logic [7:0] u, input logic act);
    bimodal_ctr  = bim;
    bank_hit     = hit;
    bank_ctr     = ctr;
    bank_u       = u;
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
    bimodal_ctr  = ~bim;
    bank_hit     = ~hit;
    bank_ctr     = ~ctr;
    bank_u       = ~u;
    o_pv = pred_valid; o_pt = pred_taken; o_prov = provider;
    tick();
    o_wait_pv = pred_valid; o_wait_busy = busy;
    o_wait_str = |{ctr_inc, ctr_dec, u_inc, u_dec, alloc_we, u_age_clear};
    resolve_valid = 1'b1;
    actual_taken  = act;
    tick();
    resolve_valid = 1'b0;
    o_ci = ctr_inc; o_cd = ctr_dec; o_ui = u_inc; o_ud = u_dec; o_aw = alloc_we;
    o_age = u_age_clear; o_tot = total_cnt; o_cor = correct_cnt; o_upd_busy = busy;
    tick();
    o_idle_busy = busy;
  endtask

  task automatic test_reset();
    lookup_valid = 0; resolve_valid = 0; actual_taken = 0;
    bimodal_ctr = 0; bank_hit = 0; bank_ctr = 0; bank_u = 0;
    apply_reset();
    tests++;
    if ({busy, pred_valid, pred_taken, provider} !== 6'b0) begin
      fails++; $display("FAIL reset_ctl got %b exp 000000", {busy, pred_valid, pred_taken, provider});
    end
    tests++;
    if ({ctr_inc, ctr_dec, u_inc, u_dec, alloc_we, u_age_clear} !== 27'b0) begin
      fails++; $display("FAIL reset_strobes got %h exp 0", {ctr_inc, ctr_dec, u_inc, u_dec, alloc_we, u_age_clear});
    end
    tests++;
    if ({correct_cnt, total_cnt} !== 34'b0) begin
      fails++; $display("FAIL reset_stats got cor=%0d tot=%0d exp 0/0", correct_cnt, total_cnt);
    end
  endtask

  task automatic test_bimodal_mispredict();
    run_op(3'b101, 4'b0000, 12'h000, 8'h00, 1'b0);
    tests++; if ({o_pv, o_pt, o_prov} !== 5'b11000) begin
      fails++; $display("FAIL t1_pred got %b exp 11000", {o_pv, o_pt, o_prov}); end
    tests++; if ({o_wait_pv, o_wait_busy, o_wait_str} !== 3'b010) begin
      fails++; $display("FAIL t1_wait got %b exp 010", {o_wait_pv, o_wait_busy, o_wait_str}); end
    tests++; if ({o_ci, o_cd} !== {5'b00000, 5'b00001}) begin
      fails++; $display("FAIL t1_ctr got inc=%b dec=%b exp inc=00000 dec=00001", o_ci, o_cd); end
    tests++; if ({o_ui, o_ud, o_aw} !== {4'b0000, 4'b0000, 4'b0001}) begin
      fails++; $display("FAIL t1_u_alloc got ui=%b ud=%b aw=%b exp 0000 0000 0001", o_ui, o_ud, o_aw); end
    tests++; if ({o_tot, o_cor, o_age} !== {17'd1, 17'd0, 1'b0}) begin
      fails++; $display("FAIL t1_stats got tot=%0d cor=%0d age=%b exp 1 0 0", o_tot, o_cor, o_age); end
    tests++; if ({o_upd_busy, o_idle_busy} !== 2'b10) begin
      fails++; $display("FAIL t1_busy got %b exp 10", {o_upd_busy, o_idle_busy}); end
  endtask

  task automatic test_provider_saturated();
    run_op(3'b000, 4'b0110, {3'b000, 3'b111, 3'b000, 3'b000}, {2'b00, 2'b10, 2'b00, 2'b00}, 1'b1);
    tests++; if ({o_pv, o_pt, o_prov} !== 5'b11011) begin
      fails++; $display("FAIL t2_pred got %b exp 11011", {o_pv, o_pt, o_prov}); end
    tests++; if ({o_ci, o_cd} !== 10'b0) begin
      fails++; $display("FAIL t2_ctr got inc=%b dec=%b exp 0 0", o_ci, o_cd); end
    tests++; if ({o_ui, o_ud, o_aw} !== {4'b0100, 4'b0000, 4'b0000}) begin
      fails++; $display("FAIL t2_u_alloc got ui=%b ud=%b aw=%b exp 0100 0000 0000", o_ui, o_ud, o_aw); end
    tests++; if ({o_tot, o_cor, o_age} !== {17'd2, 17'd1, 1'b0}) begin
      fails++; $display("FAIL t2_stats got tot=%0d cor=%0d age=%b exp 2 1 0", o_tot, o_cor, o_age); end
  endtask

  task automatic test_weak_alternate();
    run_op(3'b001, 4'b1000, {3'b100, 9'b0}, 8'h00, 1'b0);
    tests++; if ({o_pv, o_pt, o_prov} !== 5'b10100) begin
      fails++; $display("FAIL t3_pred got %b exp 10100", {o_pv, o_pt, o_prov}); end
    tests++; if ({o_ci, o_cd} !== {5'b00000, 5'b10000}) begin
      fails++; $display("FAIL t3_ctr got inc=%b dec=%b exp 00000 10000", o_ci, o_cd); end
    tests++; if ({o_ui, o_ud, o_aw} !== 12'b0) begin
      fails++; $display("FAIL t3_u_alloc got ui=%b ud=%b aw=%b exp 0 0 0", o_ui, o_ud, o_aw); end
    tests++; if ({o_tot, o_cor, o_age} !== {17'd3, 17'd2, 1'b0}) begin
      fails++; $display("FAIL t3_stats got tot=%0d cor=%0d age=%b exp 3 2 0", o_tot, o_cor, o_age); end
  endtask

  task automatic test_no_victim();
    run_op(3'b110, 4'b0001, {9'b0, 3'b111}, 8'b01010101, 1'b0);
    tests++; if ({o_pv, o_pt, o_prov} !== 5'b11001) begin
      fails++; $display("FAIL t4_pred got %b exp 11001", {o_pv, o_pt, o_prov}); end
    tests++; if ({o_ci, o_cd} !== {5'b00000, 5'b00010}) begin
      fails++; $display("FAIL t4_ctr got inc=%b dec=%b exp 00000 00010", o_ci, o_cd); end
    tests++; if ({o_ui, o_ud, o_aw} !== {4'b0000, 4'b1110, 4'b0000}) begin
      fails++; $display("FAIL t4_u_alloc got ui=%b ud=%b aw=%b exp 0000 1110 0000", o_ui, o_ud, o_aw); end
    // Fourth update since reset: the aging pulse fires here with UR_PERIOD=4.
    tests++; if ({o_tot, o_cor, o_age} !== {17'd4, 17'd2, 1'b1}) begin
      fails++; $display("FAIL t4_stats got tot=%0d cor=%0d age=%b exp 4 2 1", o_tot, o_cor, o_age); end
  endtask

  task automatic test_aging();
    logic [4:0] exp_age;
    exp_age = 5'b01000;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(3'b101, 4'b0000, 12'h000, 8'h00, 1'b1);
      tests++;
      if (o_age !== exp_age[i]) begin
        fails++; $display("FAIL age_op%0d got %b exp %b", i, o_age, exp_age[i]);
      end
    end
    tests++; if ({o_tot, o_cor} !== {17'd5, 17'd5}) begin
      fails++; $display("FAIL age_stats got tot=%0d cor=%0d exp 5 5", o_tot, o_cor); end
  endtask

  task automatic test_reset_abort();
    bimodal_ctr = 3'b111; bank_hit = 0; bank_ctr = 0; bank_u = 0;
    lookup_valid = 1'b1;
    tick();
    lookup_valid  = 1'b0;
    resolve_valid = 1'b1;   // arrives during PRED; must be ignored
    actual_taken  = 1'b1;
    tick();
    resolve_valid = 1'b0;
    lookup_valid  = 1'b1;   // arrives during WAIT; must be ignored
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({pred_valid, busy, |{ctr_inc, ctr_dec, u_inc, u_dec, alloc_we}} !== 3'b010) begin
        fails++; $display("FAIL wait_hold%0d got pv/busy/str=%b exp 010", i,
                          {pred_valid, busy, |{ctr_inc, ctr_dec, u_inc, u_dec, alloc_we}});
      end
      tick();
    end
    lookup_valid  = 1'b0;
    reset         = 1'b1;
    resolve_valid = 1'b1;
    tick();
    reset         = 1'b0;
    resolve_valid = 1'b0;
    tests++;
    if ({busy, pred_valid, |{ctr_inc, ctr_dec, u_inc, u_dec, alloc_we, u_age_clear}} !== 3'b000) begin
      fails++; $display("FAIL abort_ctl got busy/pv/str=%b exp 000",
                        {busy, pred_valid, |{ctr_inc, ctr_dec, u_inc, u_dec, alloc_we, u_age_clear}});
    end
    tests++;
    if (total_cnt !== 17'd0) begin
      fails++; $display("FAIL abort_total got %0d exp 0", total_cnt);
    end
    tick();
    tests++;
    if ({busy, |{ctr_inc, ctr_dec, alloc_we}} !== 2'b00) begin
      fails++; $display("FAIL abort_idle got %b exp 00", {busy, |{ctr_inc, ctr_dec, alloc_we}});
    end
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
    tests++;
    if ({pred_valid, pred_taken} !== 2'b11) begin
      fails++; $display("FAIL abort_relookup got %b exp 11", {pred_valid, pred_taken});
    end
    tick();
    resolve_valid = 1'b1; actual_taken = 1'b1;
    tick();
    resolve_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bimodal_ctr = 3'b010; bank_hit = 0; bank_ctr = 0; bank_u = 0;
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
    tick();
    resolve_valid = 1'b1; actual_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    lookup_valid  = 1'b1;   // held through UPD; only the following IDLE may accept it
    tests++;
    if ({busy, ctr_dec} !== {1'b1, 5'b00001}) begin
      fails++; $display("FAIL b2b_upd got busy=%b dec=%b exp 1 00001", busy, ctr_dec);
    end
    tick();
    tests++;
    if ({busy, pred_valid} !== 2'b00) begin
      fails++; $display("FAIL b2b_idle got busy/pv=%b exp 00", {busy, pred_valid});
    end
    tick();
    lookup_valid = 1'b0;
    tests++;
    if ({busy, pred_valid} !== 2'b11) begin
      fails++; $display("FAIL b2b_accept got busy/pv=%b exp 11", {busy, pred_valid});
    end
    tick();
    resolve_valid = 1'b1;
    tick();
    resolve_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_bimodal_mispredict();
    test_provider_saturated();
    test_weak_alternate();
    test_no_victim();
    test_aging();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tage_pred_update_unit.md
Name: tage_pred_update_unit

Overview:
Parametrised prediction/update engine for a TAGE predictor with NUM_BANKS tagged banks plus a bimodal base table.
- Captures one lookup's per-bank hit, counter and useful bits. Selects the provider and the alternate prediction, and emits the prediction.
- Waits for branch resolution, then issues one cycle of update strobes to the tables: counters, useful bits, allocation and periodic useful-bit aging.
- Keeps the correct/total statistics.

Parameters:
NUM_BANKS, 4, number of tagged banks; bank 1 is the shortest history and is bit 0 of all per-bank vectors.
CL, 3, prediction counter width.
UL, 2, useful counter width.
CNT_W, 17, statistics counter width.
UR_PERIOD, 256, number of updates between useful-bit aging pulses; must be at least 2.
PW, $clog2(NUM_BANKS+1), provider field width.

Ports:
CLK  in  1  clock.
reset  in  1  synchronous, active-high reset.
lookup_valid  in  1  lookup data valid; accepted only when busy=0.
bimodal_ctr  in  CL  bimodal counter.
bank_hit  in  NUM_BANKS  tag-match per bank.
bank_ctr  in  NUM_BANKS*CL  counters, bank k at [k*CL-1:(k-1)*CL].
bank_u  in  NUM_BANKS*UL  useful bits, packed the same way.
busy  out  1  high from the cycle after acceptance until the UPD cycle, inclusive.
pred_valid  out  1  one-cycle prediction strobe.
pred_taken  out  1  final prediction.
provider  out  PW  0 = bimodal, k = bank k.
resolve_valid  in  1  actual outcome valid.
actual_taken  in  1  actual branch direction.
ctr_inc, ctr_dec  out  NUM_BANKS+1  counter strobes; bit 0 = bimodal, bit k = bank k.
u_inc, u_dec  out  NUM_BANKS  useful strobes.
alloc_we  out  NUM_BANKS  one-hot allocation write.
u_age_clear  out  1  clear all useful bits.
correct_cnt, total_cnt  out  CNT_W  statistics.

Behaviour:
- Reset: state IDLE; every output 0, including both statistics counters and the aging counter. Reset in any state aborts the operation; no strobes are issued for it.
- FSM IDLE -> PRED -> WAIT -> UPD -> IDLE.
- IDLE: busy=0. On lookup_valid, register all lookup inputs and go to PRED.
- PRED: pred_valid=1 for exactly one cycle, then go to WAIT. Latency from acceptance to pred_valid is 1 cycle.
- WAIT: hold pred_taken and provider. On resolve_valid, register actual_taken and go to UPD.
- resolve_valid in IDLE or PRED is ignored. lookup_valid while busy=1 is ignored.
- UPD: all strobes are high for this one cycle only, then return to IDLE. A new lookup is accepted no earlier than the cycle after UPD.
- Provider is the highest-indexed hit bank, or 0 if there is no hit.
- Alternate is the next lower hit bank, or bimodal.
- Weak counter means ctr equals 2^(CL-1) or 2^(CL-1)-1.
- pred_taken = the alternate's counter MSB when the provider is nonzero, weak, and has u=0. Otherwise pred_taken = the provider's counter MSB.
- correct = (pred_taken == actual_taken).
- Provider counter: ctr_inc if taken, ctr_dec if not taken. The strobe is suppressed at saturation (all ones / zero). Only the provider's counter is touched.
- Useful bits (provider nonzero, and provider MSB differs from alternate MSB): u_inc if the provider MSB was correct, else u_dec. Suppressed at saturation.
- Allocation on a mispredict with provider < NUM_BANKS:
  - alloc_we one-hot on the lowest bank j > provider with u=0.
  - If no such bank exists, alloc_we=0 and u_dec is asserted on every bank > provider with u>0.
- Aging: a counter increments on each UPD. When it reaches UR_PERIOD-1, u_age_clear=1 in that UPD cycle and the counter wraps to 0.
- Statistics in UPD: total_cnt += 1; correct_cnt += correct. Both saturate at all ones.

Test Plan:
1. Reset; bimodal_ctr=3'b101, bank_hit=0, lookup -> next cycle pred_valid=1, pred_taken=1, provider=0. Resolve actual=0 -> UPD: ctr_dec=5'b00001, alloc_we=4'b0001, total_cnt=1, correct_cnt=0.
2. bank_hit=4'b0110, bank3 ctr=3'b111 u=2'b10, bank2 ctr=3'b000; actual=1 -> provider=3, pred_taken=1, ctr_inc=0 (saturated), u_inc=4'b0100, alloc_we=0, correct_cnt+1.
3. bank_hit=4'b1000, bank4 ctr=3'b100 u=0, bimodal=3'b001 -> pred_taken=0 (alternate used), provider=4.
4. Mispredict with provider=1 and banks 2-4 u=2'b01 -> alloc_we=0, u_dec=4'b1110.
5. UR_PERIOD=4, four complete operations -> u_age_clear=1 only in the fourth UPD cycle; the fifth UPD has no pulse.
6. Reset asserted in WAIT, then resolve_valid=1 -> no strobes, busy=0, total_cnt=0. A lookup_valid during WAIT is ignored: pred_valid stays low until the next IDLE acceptance.
